// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths, ALU opcodes and the EX control bundle.
// Rev 1.0
`default_nettype none

package cpu_pkg;

  localparam int DW     = 16;
  localparam int REG_AW = 3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_NOT = 3'd2;
  localparam logic [2:0] ALU_SHL = 3'd3;
  localparam logic [2:0] ALU_SHR = 3'd4;
  localparam logic [2:0] ALU_AND = 3'd5;
  localparam logic [2:0] ALU_OR  = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ex_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if: ID, forwarding-source and EX-side signals of the operand stage.
// Rev 1.0
`default_nettype none

interface ex_operand_stage_if
  import cpu_pkg::*;
#(
  parameter int DW     = cpu_pkg::DW,
  parameter int REG_AW = cpu_pkg::REG_AW
);

  logic              id_valid;
  logic [2:0]        id_alu_control;
  logic [REG_AW-1:0] id_rs_addr;
  logic [REG_AW-1:0] id_rt_addr;
  logic [DW-1:0]     id_rs_data;
  logic [DW-1:0]     id_rt_data;
  logic [DW-1:0]     id_imm;
  logic              id_use_imm;
  logic [REG_AW-1:0] id_rd_addr;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic [DW-1:0]     alu_result;
  logic              mem_reg_write;
  logic [REG_AW-1:0] mem_rd_addr;
  logic [DW-1:0]     mem_data;
  logic              stall_in;
  logic              flush;

  logic              ex_valid;
  logic [2:0]        alu_control;
  logic [DW-1:0]     input_A;
  logic [DW-1:0]     input_B;
  logic [DW-1:0]     ex_store_data;
  logic [REG_AW-1:0] ex_rd_addr;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              stall_out;

  modport master (
    output id_valid, id_alu_control, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
           id_imm, id_use_imm, id_rd_addr, id_reg_write, id_mem_read, id_mem_write,
           alu_result, mem_reg_write, mem_rd_addr, mem_data, stall_in, flush,
    input  ex_valid, alu_control, input_A, input_B, ex_store_data, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_mem_write, stall_out
  );

  modport slave (
    input  id_valid, id_alu_control, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
           id_imm, id_use_imm, id_rd_addr, id_reg_write, id_mem_read, id_mem_write,
           alu_result, mem_reg_write, mem_rd_addr, mem_data, stall_in, flush,
    output ex_valid, alu_control, input_A, input_B, ex_store_data, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_mem_write, stall_out
  );

endinterface

`default_nettype wire

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux: per-source operand select (R0 zero, EX forward, MEM forward, register file).
// Rev 1.0
`default_nettype none

module operand_fwd_mux #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  wire logic [AW-1:0] i_src_addr,
  input  wire logic [DW-1:0] i_rf_data,
  input  wire logic          i_ex_fwd_en,
  input  wire logic [AW-1:0] i_ex_rd_addr,
  input  wire logic [DW-1:0] i_ex_data,
  input  wire logic          i_mem_reg_write,
  input  wire logic [AW-1:0] i_mem_rd_addr,
  input  wire logic [DW-1:0] i_mem_data,
  output logic      [DW-1:0] o_data
);

  // The younger (EX) producer wins over MEM when both target the same register.
  always_comb begin
    o_data = i_rf_data;
    if (i_src_addr == '0) begin
      o_data = '0;
    end else if (i_ex_fwd_en && (i_ex_rd_addr == i_src_addr)) begin
      o_data = i_ex_data;
    end else if (i_mem_reg_write && (i_mem_rd_addr == i_src_addr)) begin
      o_data = i_mem_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Rev 1.0
`default_nettype none

module ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int DW     = cpu_pkg::DW,
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input wire logic          clk,
  input wire logic          rst_n,
  ex_operand_stage_if.slave bus
);

  logic              r_valid;
  logic [2:0]        r_alu_control;
  logic [DW-1:0]     r_input_a;
  logic [DW-1:0]     r_input_b;
  logic [DW-1:0]     r_store_data;
  logic [REG_AW-1:0] r_rd_addr;
  ex_ctrl_t          r_ctrl;

  logic              w_ex_fwd_en;
  logic              w_rt_used;
  logic              w_load_use;
  logic [DW-1:0]     w_rs_fwd;
  logic [DW-1:0]     w_rt_fwd;

  // A load in EX has no result yet, so it can never be an EX forwarding source.
  assign w_ex_fwd_en = r_valid & r_ctrl.reg_write & ~r_ctrl.mem_read;
  assign w_rt_used   = ~bus.id_use_imm | bus.id_mem_write;
  assign w_load_use  = r_valid & r_ctrl.mem_read & (r_rd_addr != '0) &
                       ((r_rd_addr == bus.id_rs_addr) |
                        (w_rt_used & (r_rd_addr == bus.id_rt_addr)));

  assign bus.stall_out = bus.stall_in | w_load_use;

  operand_fwd_mux #(.DW(DW), .AW(REG_AW)) u_fwd_rs (
    .i_src_addr      (bus.id_rs_addr),
    .i_rf_data       (bus.id_rs_data),
    .i_ex_fwd_en     (w_ex_fwd_en),
    .i_ex_rd_addr    (r_rd_addr),
    .i_ex_data       (bus.alu_result),
    .i_mem_reg_write (bus.mem_reg_write),
    .i_mem_rd_addr   (bus.mem_rd_addr),
    .i_mem_data      (bus.mem_data),
    .o_data          (w_rs_fwd)
  );

  operand_fwd_mux #(.DW(DW), .AW(REG_AW)) u_fwd_rt (
    .i_src_addr      (bus.id_rt_addr),
    .i_rf_data       (bus.id_rt_data),
    .i_ex_fwd_en     (w_ex_fwd_en),
    .i_ex_rd_addr    (r_rd_addr),
    .i_ex_data       (bus.alu_result),
    .i_mem_reg_write (bus.mem_reg_write),
    .i_mem_rd_addr   (bus.mem_rd_addr),
    .i_mem_data      (bus.mem_data),
    .o_data          (w_rt_fwd)
  );

  // Priority: flush > stall_in > load-use bubble > capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid       <= 1'b0;
      r_alu_control <= ALU_ADD;
      r_input_a     <= '0;
      r_input_b     <= '0;
      r_store_data  <= '0;
      r_rd_addr     <= '0;
      r_ctrl        <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (!bus.stall_in) begin
      if (w_load_use) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
      end else begin
        r_valid          <= bus.id_valid;
        r_alu_control    <= bus.id_alu_control;
        r_input_a        <= w_rs_fwd;
        r_input_b        <= bus.id_use_imm ? bus.id_imm : w_rt_fwd;
        r_store_data     <= w_rt_fwd;
        r_rd_addr        <= bus.id_rd_addr;
        r_ctrl.reg_write <= bus.id_reg_write & bus.id_valid;
        r_ctrl.mem_read  <= bus.id_mem_read  & bus.id_valid;
        r_ctrl.mem_write <= bus.id_mem_write & bus.id_valid;
      end
    end
  end

  assign bus.ex_valid      = r_valid;
  assign bus.alu_control   = r_alu_control;
  assign bus.input_A       = r_input_a;
  assign bus.input_B       = r_input_b;
  assign bus.ex_store_data = r_store_data;
  assign bus.ex_rd_addr    = r_rd_addr;
  assign bus.ex_reg_write  = r_ctrl.reg_write;
  assign bus.ex_mem_read   = r_ctrl.mem_read;
  assign bus.ex_mem_write  = r_ctrl.mem_write;

endmodule

`default_nettype wire
